// File: rtl/rotate_pkg.sv
// Shared types and codes for the rotator command sequencer: command opcodes,
// rotator enable codes, default word width and sequencer FSM states.
package rotate_pkg;

  localparam int DEFAULT_WIDTH = 100;

  typedef enum logic [1:0] {
    OP_NOP       = 2'd0,
    OP_LOAD      = 2'd1,
    OP_ROT_RIGHT = 2'd2,
    OP_ROT_LEFT  = 2'd3
  } rot_op_e;

  localparam logic [1:0] ENA_HOLD  = 2'b00;
  localparam logic [1:0] ENA_RIGHT = 2'b01;
  localparam logic [1:0] ENA_LEFT  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ROT  = 2'd2,
    ST_ACK  = 2'd3
  } seq_state_e;

  function automatic logic [1:0] flip_dir(input logic [1:0] dir);
    case (dir)
      ENA_RIGHT: flip_dir = ENA_LEFT;
      ENA_LEFT:  flip_dir = ENA_RIGHT;
      default:   flip_dir = ENA_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/rot_amount_norm.sv
// Maps a rotate command to the cheaper direction and step count: the amount is
// folded modulo WIDTH, and anything past half a turn goes the other way.
module rot_amount_norm
  import rotate_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AMT_W = 7
) (
  input  rot_op_e          op,
  input  logic [AMT_W-1:0] amt,
  output logic [1:0]       dir,
  output logic [AMT_W-1:0] steps
);

  localparam logic [AMT_W-1:0] WIDTH_A = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] HALF_A  = AMT_W'(WIDTH / 2);

  logic [AMT_W-1:0] eff_s;
  logic [1:0]       req_dir_s;

  // Fold the amount once (2^AMT_W < 2*WIDTH) and pick the shorter direction.
  always_comb begin
    eff_s     = (amt >= WIDTH_A) ? (amt - WIDTH_A) : amt;
    req_dir_s = ENA_HOLD;
    dir       = ENA_HOLD;
    steps     = '0;
    case (op)
      OP_ROT_RIGHT: req_dir_s = ENA_RIGHT;
      OP_ROT_LEFT:  req_dir_s = ENA_LEFT;
      default:      req_dir_s = ENA_HOLD;
    endcase
    if (req_dir_s == ENA_HOLD) begin
      dir   = ENA_HOLD;
      steps = '0;
    end else if (eff_s > HALF_A) begin
      dir   = flip_dir(req_dir_s);
      steps = WIDTH_A - eff_s;
    end else begin
      dir   = req_dir_s;
      steps = eff_s;
    end
  end

endmodule

// File: rtl/rotate_cmd_seq.sv
// Command sequencer feeding the load/rotate register: expands LOAD and ROT
// commands into per-cycle load/ena/data drive and tracks where bit 0 went.
module rotate_cmd_seq
  import rotate_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AMT_W = 7
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [AMT_W-1:0]         cmd_amt,
  input  logic [WIDTH-1:0]         cmd_data,
  input  logic                     abort,
  output logic                     load,
  output logic [1:0]               ena,
  output logic [WIDTH-1:0]         data,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] rot_pos
);

  localparam int                POS_W   = $clog2(WIDTH);
  localparam logic [POS_W-1:0]  POS_MAX = POS_W'(WIDTH - 1);

  seq_state_e       state_r, state_s;
  logic [AMT_W-1:0] remain_r, remain_s;
  logic             load_s, done_s;
  logic [1:0]       ena_s;
  logic [WIDTH-1:0] data_s;
  logic [POS_W-1:0] rot_pos_s;
  rot_op_e          op_s;
  logic [1:0]       dir_s;
  logic [AMT_W-1:0] steps_s;
  logic             accept_s;

  assign op_s      = rot_op_e'(cmd_op);
  assign cmd_ready = (state_r == ST_IDLE) && !areset;
  assign accept_s  = cmd_valid && cmd_ready;

  rot_amount_norm #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_norm (
    .op    (op_s),
    .amt   (cmd_amt),
    .dir   (dir_s),
    .steps (steps_s)
  );

  // Next state and next drive values; outputs describe the cycle being entered.
  always_comb begin
    state_s  = state_r;
    remain_s = remain_r;
    load_s   = 1'b0;
    ena_s    = ENA_HOLD;
    done_s   = 1'b0;
    data_s   = data;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (op_s)
            OP_LOAD: begin
              state_s = ST_LOAD;
              load_s  = 1'b1;
              done_s  = 1'b1;
              data_s  = cmd_data;
            end
            OP_ROT_RIGHT, OP_ROT_LEFT: begin
              if (steps_s == '0) begin
                state_s = ST_ACK;
                done_s  = 1'b1;
              end else begin
                state_s  = ST_ROT;
                ena_s    = dir_s;
                remain_s = steps_s;
                done_s   = (steps_s == AMT_W'(1));
              end
            end
            default: state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD, ST_ACK: state_s = ST_IDLE;
      ST_ROT: begin
        // The step on the bus at an abort edge still lands; nothing follows it.
        if (abort || (remain_r <= AMT_W'(1))) begin
          state_s  = ST_IDLE;
          remain_s = '0;
        end else begin
          ena_s    = ena;
          remain_s = remain_r - AMT_W'(1);
          done_s   = (remain_r == AMT_W'(2));
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Bit-0 position follows what the rotator does with the current drive.
  always_comb begin
    if (load) begin
      rot_pos_s = '0;
    end else if (ena == ENA_RIGHT) begin
      rot_pos_s = (rot_pos == '0) ? POS_MAX : (rot_pos - POS_W'(1));
    end else if (ena == ENA_LEFT) begin
      rot_pos_s = (rot_pos == POS_MAX) ? '0 : (rot_pos + POS_W'(1));
    end else begin
      rot_pos_s = rot_pos;
    end
  end

  // State and registered rotator drive.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_r  <= ST_IDLE;
      remain_r <= '0;
      load     <= 1'b0;
      ena      <= ENA_HOLD;
      data     <= '0;
      done     <= 1'b0;
      rot_pos  <= '0;
    end else begin
      state_r  <= state_s;
      remain_r <= remain_s;
      load     <= load_s;
      ena      <= ena_s;
      data     <= data_s;
      done     <= done_s;
      rot_pos  <= rot_pos_s;
    end
  end

endmodule

// File: tb/tb_rotate_cmd_seq.sv
// Bench for rotate_cmd_seq: directed table, hand-written corner sequences and
// random commands checked against a model and a reference rotator.
module tb_rotate_cmd_seq;
  import rotate_pkg::*;

  localparam int W  = 100;
  localparam int AW = 7;
  localparam int PW = $clog2(W);

  logic          clk = 1'b0;
  logic          areset, cmd_valid, abort, load, done, cmd_ready;
  logic [1:0]    cmd_op, ena;
  logic [AW-1:0] cmd_amt;
  logic [W-1:0]  cmd_data, data;
  logic [PW-1:0] rot_pos;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] ref_q;
  logic [W-1:0] mdl_word;
  int           mdl_pos;
  bit           mdl_valid;

  typedef struct {
    logic [1:0]   op;
    int           amt;
    logic [W-1:0] d;
    logic [1:0]   dir;
    int           steps;
  } vec_t;
  vec_t vecs[13];

  always #5 clk = ~clk;

  rotate_cmd_seq #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk       (clk),
    .areset    (areset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .cmd_data  (cmd_data),
    .abort     (abort),
    .load      (load),
    .ena       (ena),
    .data      (data),
    .done      (done),
    .rot_pos   (rot_pos)
  );

  // Reference rotator consuming the DUT drive.
  always @(posedge clk) begin
    if (load) ref_q <= data;
    else if (ena == 2'b01) ref_q <= {ref_q[0], ref_q[W-1:1]};
    else if (ena == 2'b10) ref_q <= {ref_q[W-2:0], ref_q[W-1]};
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rotl(input logic [W-1:0] w, input int n);
    return (w << n) | (w >> (W - n));
  endfunction

  function automatic void model_norm(input logic [1:0] op, input int amt,
                                     output logic [1:0] dir, output int steps);
    int eff;
    eff   = amt % W;
    dir   = 2'b00;
    steps = 0;
    if (op == 2'd2 || op == 2'd3) begin
      dir = (op == 2'd2) ? 2'b01 : 2'b10;
      if (eff > W / 2) begin
        steps = W - eff;
        dir   = (op == 2'd2) ? 2'b10 : 2'b01;
      end else begin
        steps = eff;
      end
      if (steps == 0) dir = 2'b00;
    end
  endfunction

  task automatic check_model(input string tag);
    chk({tag, " rot_pos"}, rot_pos, mdl_pos);
    if (mdl_valid) begin
      chk({tag, " data"}, data, mdl_word);
      chk({tag, " ref_q"}, ref_q, rotl(mdl_word, mdl_pos));
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input int amt, input logic [W-1:0] d,
                         input int abort_at, input string tag,
                         output int obs_n, output logic [1:0] obs_dir);
    int cyc, n_ena, n_done, n_load, done_cyc, exp_n, exp_cycles, steps;
    logic [1:0] exp_dir;
    bit overlap, ready_hi, dir_bad, is_rot, exp_done;
    model_norm(op, amt, exp_dir, steps);
    is_rot = (op == 2'd2 || op == 2'd3);
    exp_n  = (abort_at > 0) ? abort_at : steps;
    obs_n = 0;
    obs_dir = 2'b00;
    cyc = 0;
    @(negedge clk);
    while (!cmd_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " ready_wait"}, cmd_ready, 1'b1);
    if (!cmd_ready) return;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = AW'(amt);
    cmd_data  = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    n_ena = 0; n_done = 0; n_load = 0; done_cyc = -1; cyc = 0;
    overlap = 0; ready_hi = 0; dir_bad = 0;
    while (cyc < 200) begin
      if (!load && ena == 2'b00 && !done) break;
      if (load && ena != 2'b00) overlap = 1;
      if (cmd_ready) ready_hi = 1;
      if (load) n_load++;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (ena != 2'b00) begin
        if (n_ena == 0) obs_dir = ena;
        else if (ena != obs_dir) dir_bad = 1;
        n_ena++;
      end
      cyc++;
      if (abort_at > 0 && n_ena == abort_at && ena != 2'b00) abort = 1'b1;
      @(posedge clk);
      #1;
      if (abort_at > 0) abort = 1'b0;
    end
    obs_n = n_ena;
    exp_done   = (op == 2'd1) || (is_rot && abort_at == 0);
    exp_cycles = (op == 2'd1) ? 1 : (is_rot ? ((steps == 0) ? 1 : exp_n) : 0);
    chk({tag, " timeout"}, (cyc < 200), 1'b1);
    chk({tag, " ready_after"}, cmd_ready, 1'b1);
    chk({tag, " ready_busy"}, ready_hi, 1'b0);
    chk({tag, " overlap"}, overlap, 1'b0);
    chk({tag, " cycles"}, cyc, exp_cycles);
    chk({tag, " n_ena"}, n_ena, exp_n);
    chk({tag, " n_load"}, n_load, (op == 2'd1) ? 1 : 0);
    chk({tag, " n_done"}, n_done, exp_done ? 1 : 0);
    if (exp_done) chk({tag, " done_last"}, done_cyc, cyc - 1);
    if (exp_n > 0) begin
      chk({tag, " dir"}, obs_dir, exp_dir);
      chk({tag, " dir_stable"}, dir_bad, 1'b0);
    end
    if (op == 2'd1) begin
      mdl_word  = d;
      mdl_pos   = 0;
      mdl_valid = 1;
    end else if (is_rot) begin
      if (exp_dir == 2'b01) mdl_pos = (mdl_pos - exp_n + W) % W;
      else mdl_pos = (mdl_pos + exp_n) % W;
    end
    check_model(tag);
  endtask

  initial begin
    int on;
    logic [1:0] od;
    logic [1:0] hs_op[5];
    int hs_amt[5];
    logic [W-1:0] hs_d[5];
    int idx, nl, ne, nd;

    vecs[0]  = '{2'd1, 0,   W'(100'h5), 2'b00, 0};
    vecs[1]  = '{2'd2, 3,   '0, 2'b01, 3};
    vecs[2]  = '{2'd1, 0,   W'(100'hABCDEF0123456789), 2'b00, 0};
    vecs[3]  = '{2'd3, 120, '0, 2'b10, 20};
    vecs[4]  = '{2'd3, 75,  '0, 2'b01, 25};
    vecs[5]  = '{2'd2, 100, '0, 2'b00, 0};
    vecs[6]  = '{2'd2, 0,   '0, 2'b00, 0};
    vecs[7]  = '{2'd3, 50,  '0, 2'b10, 50};
    vecs[8]  = '{2'd2, 51,  '0, 2'b10, 49};
    vecs[9]  = '{2'd3, 99,  '0, 2'b01, 1};
    vecs[10] = '{2'd2, 127, '0, 2'b01, 27};
    vecs[11] = '{2'd3, 60,  '0, 2'b01, 40};
    vecs[12] = '{2'd0, 5,   '0, 2'b00, 0};

    areset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_amt = '0;
    cmd_data = '0; abort = 1'b0;
    mdl_pos = 0; mdl_valid = 0; mdl_word = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst load", load, 1'b0);
    chk("rst ena", ena, 2'b00);
    chk("rst data", data, '0);
    chk("rst done", done, 1'b0);
    chk("rst rot_pos", rot_pos, '0);
    chk("rst ready", cmd_ready, 1'b0);
    @(negedge clk);
    areset = 1'b0;
    #1;
    chk("rel ready", cmd_ready, 1'b1);

    // areset in the middle of a rotation clears the drive asynchronously
    run_cmd(2'd1, 0, W'(100'h3), 0, "pre_rst", on, od);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_amt = AW'(30);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid ena_before", ena, 2'b01);
    areset = 1'b1;
    #1;
    chk("mid ena", ena, 2'b00);
    chk("mid load", load, 1'b0);
    chk("mid done", done, 1'b0);
    chk("mid rot_pos", rot_pos, '0);
    chk("mid data", data, '0);
    chk("mid ready", cmd_ready, 1'b0);
    @(negedge clk);
    areset = 1'b0;
    #1;
    chk("mid ready_rel", cmd_ready, 1'b1);
    mdl_pos = 0; mdl_valid = 0;

    for (int i = 0; i < 13; i++) begin
      run_cmd(vecs[i].op, vecs[i].amt, vecs[i].d, 0, $sformatf("vec%0d", i), on, od);
      chk($sformatf("vec%0d tbl_steps", i), on, vecs[i].steps);
      if (vecs[i].steps > 0) chk($sformatf("vec%0d tbl_dir", i), od, vecs[i].dir);
    end

    // abort on the 5th step of a 30-step right rotation
    run_cmd(2'd1, 0, W'(100'h1), 0, "ab_load", on, od);
    run_cmd(2'd2, 30, '0, 5, "abort", on, od);
    chk("abort rot_pos", rot_pos, 7'd95);

    // abort outside ROT has no effect
    abort = 1'b1;
    run_cmd(2'd1, 0, W'(100'h77), 0, "ign_load", on, od);
    run_cmd(2'd2, 100, '0, 0, "ign_ack", on, od);
    abort = 1'b0;

    // back-to-back commands with cmd_valid held high
    hs_op  = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd3};
    hs_amt = '{0, 2, 7, 0, 3};
    hs_d   = '{W'(100'h1234), '0, '0, W'(100'hF00D), '0};
    idx = 0; nl = 0; ne = 0; nd = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (load) nl++;
      if (ena != 2'b00) ne++;
      if (done) nd++;
      if (idx < 5) begin
        cmd_valid = 1'b1;
        cmd_op    = hs_op[idx];
        cmd_amt   = AW'(hs_amt[idx]);
        cmd_data  = hs_d[idx];
        if (cmd_ready) idx++;
      end else begin
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    chk("hs accepted", idx, 5);
    chk("hs loads", nl, 2);
    chk("hs ena_cycles", ne, 5);
    chk("hs dones", nd, 4);
    mdl_word = W'(100'hF00D); mdl_pos = 3; mdl_valid = 1;
    check_model("hs");

    // random commands against the model
    run_cmd(2'd1, 0, {$urandom(), $urandom(), $urandom(), $urandom()}, 0, "rnd_load", on, od);
    for (int i = 0; i < 40; i++) begin
      logic [1:0] rop, rdir;
      int ramt, rsteps, rab;
      rop  = 2'($urandom_range(0, 3));
      ramt = $urandom_range(0, 127);
      model_norm(rop, ramt, rdir, rsteps);
      rab = 0;
      if (rsteps > 1 && $urandom_range(0, 4) == 0) rab = $urandom_range(1, rsteps - 1);
      run_cmd(rop, ramt, {$urandom(), $urandom(), $urandom(), $urandom()}, rab,
              $sformatf("rnd%0d", i), on, od);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
